// File: rtl/slave_spi.sv
// SPI target in the CLK domain: SCLK idles high, both ends sample on SCLK falling, MSB first.
// Bytes move through a one-deep transmit buffer and a one-deep receive holding register.
module slave_spi #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL        = 8'hFF
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  output logic       FRAME,
  input  logic [7:0] TX_DATA,
  input  logic       TX_WR,
  output logic       TX_FULL,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_ACK,
  output logic       OVERRUN,
  input  logic       OVR_CLR
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] ss_sync_p0, sclk_sync_p0, mosi_sync_p0;
  logic                   ss_p1, sclk_p1;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_fall, sclk_rise;

  state_t     state_q, state_d;
  logic       start, stop, fall_ev, rise_ev, active;
  logic [2:0] bit_cnt;
  logic [6:0] tx_shift, rx_shift;
  logic [7:0] tx_buf, rx_data_q, load_byte, rx_next;
  logic       tx_full_q, rx_valid_q, overrun_q, miso_q;
  logic       load_pt, wr_ok, byte_done, rx_take, ovr_set;

  // Stage p0: input synchronizers; stage p1: delayed copy for edge detection
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      ss_sync_p0   <= '1;
      sclk_sync_p0 <= '1;
      mosi_sync_p0 <= '0;
      ss_p1        <= 1'b1;
      sclk_p1      <= 1'b1;
    end else begin
      ss_sync_p0   <= {ss_sync_p0[SYNC_STAGES-2:0], SS};
      sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], SCLK};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], MOSI};
      ss_p1        <= ss_sync_p0[SYNC_STAGES-1];
      sclk_p1      <= sclk_sync_p0[SYNC_STAGES-1];
    end
  end

  assign ss_s      = ss_sync_p0[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_p0[SYNC_STAGES-1];
  assign ss_fall   = ss_p1 & ~ss_s;
  assign ss_rise   = ~ss_p1 & ss_s;
  assign sclk_fall = sclk_p1 & ~sclk_s;
  assign sclk_rise = ~sclk_p1 & sclk_s;

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // SS rising wins over a coincident SCLK edge, so a frame end never shifts
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    fall_ev = 1'b0;
    rise_ev = 1'b0;
    active  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        active = 1'b1;
        if (ss_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          fall_ev = sclk_fall;
          rise_ev = sclk_rise;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_pt   = start | (rise_ev & (bit_cnt == 3'd0));
  assign load_byte = tx_full_q ? tx_buf : FILL;
  assign rx_next   = {rx_shift, mosi_s};
  assign byte_done = fall_ev & (bit_cnt == 3'd7);
  assign rx_take   = byte_done & (~rx_valid_q | RX_ACK);
  assign ovr_set   = byte_done & ~rx_take;
  // A write coinciding with a load lands even when full: the load drains the old byte
  assign wr_ok     = TX_WR & (~tx_full_q | load_pt);

  // Transmit path: MISO always presents the MSB of the byte being shifted
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      tx_shift <= '0;
      miso_q   <= 1'b0;
    end else if (load_pt) begin
      tx_shift <= load_byte[6:0];
      miso_q   <= load_byte[7];
    end else if (rise_ev) begin
      tx_shift <= {tx_shift[5:0], 1'b0};
      miso_q   <= tx_shift[6];
    end
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      tx_buf    <= '0;
      tx_full_q <= 1'b0;
    end else begin
      if (wr_ok) tx_buf <= TX_DATA;
      tx_full_q <= wr_ok | (tx_full_q & ~load_pt);
    end
  end

  // Receive path
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      if (start | stop) bit_cnt <= 3'd0;
      else if (fall_ev) bit_cnt <= bit_cnt + 3'd1;
      if (fall_ev) rx_shift <= rx_next[6:0];
    end
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (rx_take) begin
        rx_data_q  <= rx_next;
        rx_valid_q <= 1'b1;
      end else if (RX_ACK) begin
        rx_valid_q <= 1'b0;
      end
      overrun_q <= ovr_set | (overrun_q & ~OVR_CLR);
    end
  end

  assign MISO     = miso_q;
  assign MISO_OE  = active;
  assign FRAME    = active;
  assign TX_FULL  = tx_full_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_slave_spi.sv
// Bench for slave_spi: a bit-level SPI master drives the pins while a byte-level
// model of the transmit buffer and receive register predicts every observable result.
module tb_slave_spi;

  localparam int H     = 6;  // SCLK half period in CLK cycles
  localparam int SETUP = 8;  // SS low to first SCLK fall

  logic       CLK, RES_N, SS, SCLK, MOSI;
  logic       MISO, MISO_OE, FRAME;
  logic [7:0] TX_DATA;
  logic       TX_WR, TX_FULL;
  logic [7:0] RX_DATA;
  logic       RX_VALID, RX_ACK, OVERRUN, OVR_CLR;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic       m_tx_full, m_rx_valid, m_ovr;
  logic [7:0] m_tx_buf, m_rx_data, m_loaded;

  slave_spi #(.SYNC_STAGES(2), .FILL(8'hFF)) dut (
    .CLK(CLK), .RES_N(RES_N), .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .FRAME(FRAME),
    .TX_DATA(TX_DATA), .TX_WR(TX_WR), .TX_FULL(TX_FULL),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ACK(RX_ACK),
    .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic void model_reset();
    m_tx_full = 1'b0; m_tx_buf = 8'h00; m_loaded = 8'h00;
    m_rx_valid = 1'b0; m_rx_data = 8'h00; m_ovr = 1'b0;
  endfunction

  // a load point hands the buffered byte (or the fill byte) to the shifter
  function automatic void model_take();
    m_loaded  = m_tx_full ? m_tx_buf : 8'hFF;
    m_tx_full = 1'b0;
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    if (!m_rx_valid) begin
      m_rx_data  = b;
      m_rx_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  task automatic tx_write(input logic [7:0] d);
    TX_DATA = d; TX_WR = 1'b1;
    tick(1);
    TX_WR = 1'b0;
    if (!m_tx_full) begin
      m_tx_buf  = d;
      m_tx_full = 1'b1;
    end
  endtask

  task automatic rx_ack();
    RX_ACK = 1'b1; tick(1); RX_ACK = 1'b0;
    m_rx_valid = 1'b0;
  endtask

  task automatic ovr_clear();
    OVR_CLR = 1'b1; tick(1); OVR_CLR = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic frame_begin();
    SS = 1'b0;
    model_take();
    tick(SETUP);
  endtask

  task automatic frame_end();
    tick(2);
    SS = 1'b1;
    tick(SETUP);
  endtask

  // master side of nbits bits; mi holds what the master sampled on each SCLK fall
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi,
                      output logic [7:0] exp_mi, output int lat);
    mi = 8'h00; lat = -1; exp_mi = m_loaded;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      tick(2);
      mi = {mi[6:0], MISO};
      SCLK = 1'b0;
      for (int c = 1; c <= H; c++) begin
        tick(1);
        if (lat < 0 && RX_VALID === 1'b1) lat = c;
      end
      SCLK = 1'b1;
      tick(H - 2);
    end
    if (nbits == 8) begin
      model_rx(mo);
      model_take();
    end else begin
      exp_mi = m_loaded >> (8 - nbits);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({MISO, MISO_OE, FRAME, TX_FULL, RX_VALID, OVERRUN, RX_DATA} !== 14'h0) begin
      errors++;
      $display("FAIL reset_hold: got %b_%b_%b_%b_%b_%b_%h expected all zero",
               MISO, MISO_OE, FRAME, TX_FULL, RX_VALID, OVERRUN, RX_DATA);
    end
    RES_N = 1'b1;
    tick(5);
    checks++;
    if ({MISO, MISO_OE, FRAME, TX_FULL, RX_VALID, OVERRUN, RX_DATA} !== 14'h0) begin
      errors++;
      $display("FAIL reset_release: got %b_%b_%b_%b_%b_%b_%h expected all zero",
               MISO, MISO_OE, FRAME, TX_FULL, RX_VALID, OVERRUN, RX_DATA);
    end
  endtask

  task automatic test_preload();
    logic [7:0] mi, ex; int lat;
    tx_write(8'hA5);
    checks++;
    if (TX_FULL !== 1'b1) begin errors++; $display("FAIL preload_full: got %b expected 1", TX_FULL); end
    frame_begin();
    checks++;
    if ({MISO_OE, FRAME, MISO, TX_FULL} !== 4'b1110) begin
      errors++; $display("FAIL preload_start: oe/frame/miso/full got %b expected 1110", {MISO_OE, FRAME, MISO, TX_FULL});
    end
    xfer(8'h3C, 8, mi, ex, lat);
    checks++;
    if (mi !== 8'hA5) begin errors++; $display("FAIL preload_miso: got %h expected a5", mi); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rx_valid_latency: got %0d expected 3", lat); end
    checks++;
    if ({RX_VALID, RX_DATA} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL preload_rx: got %b/%h expected 1/3c", RX_VALID, RX_DATA);
    end
    frame_end();
    checks++;
    if ({MISO_OE, FRAME} !== 2'b00) begin errors++; $display("FAIL preload_end: got %b expected 00", {MISO_OE, FRAME}); end
    rx_ack();
    checks++;
    if (RX_VALID !== 1'b0) begin errors++; $display("FAIL preload_ack: got %b expected 0", RX_VALID); end
  endtask

  task automatic test_fill_ack();
    logic [7:0] mi, ex; int lat;
    frame_begin();
    xfer(8'h01, 8, mi, ex, lat);
    checks++;
    if ({mi, RX_DATA} !== {8'hFF, 8'h01}) begin
      errors++; $display("FAIL fill_byte0: miso/rx got %h/%h expected ff/01", mi, RX_DATA);
    end
    rx_ack();
    xfer(8'h02, 8, mi, ex, lat);
    checks++;
    if ({mi, RX_DATA, RX_VALID, OVERRUN} !== {8'hFF, 8'h02, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fill_byte1: miso/rx/valid/ovr got %h/%h/%b/%b expected ff/02/1/0", mi, RX_DATA, RX_VALID, OVERRUN);
    end
    frame_end();
    rx_ack();
  endtask

  task automatic test_overrun();
    logic [7:0] mi, ex; int lat;
    frame_begin();
    xfer(8'h5A, 8, mi, ex, lat);
    xfer(8'h96, 8, mi, ex, lat);
    checks++;
    if ({RX_DATA, RX_VALID, OVERRUN} !== {8'h5A, 1'b1, 1'b1}) begin
      errors++; $display("FAIL overrun_set: rx/valid/ovr got %h/%b/%b expected 5a/1/1", RX_DATA, RX_VALID, OVERRUN);
    end
    frame_end();
    ovr_clear();
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b expected 0", OVERRUN); end
    rx_ack();
  endtask

  task automatic test_abort();
    logic [7:0] mi, ex; int lat;
    tx_write(8'hE7);
    frame_begin();
    xfer(8'hB4, 5, mi, ex, lat);
    checks++;
    if (mi !== 8'h1C) begin errors++; $display("FAIL abort_miso: got %h expected 1c", mi); end
    frame_end();
    checks++;
    if ({RX_VALID, MISO_OE, OVERRUN, TX_FULL} !== 4'b0000) begin
      errors++; $display("FAIL abort_state: valid/oe/ovr/full got %b expected 0000", {RX_VALID, MISO_OE, OVERRUN, TX_FULL});
    end
    frame_begin();
    xfer(8'h4B, 8, mi, ex, lat);
    checks++;
    if ({mi, RX_DATA, RX_VALID} !== {8'hFF, 8'h4B, 1'b1}) begin
      errors++; $display("FAIL abort_next: miso/rx/valid got %h/%h/%b expected ff/4b/1", mi, RX_DATA, RX_VALID);
    end
    frame_end();
    rx_ack();
  endtask

  task automatic test_double_wr();
    logic [7:0] mi, ex; int lat;
    tx_write(8'h11);
    tx_write(8'h22);
    checks++;
    if (TX_FULL !== 1'b1) begin errors++; $display("FAIL double_wr_full: got %b expected 1", TX_FULL); end
    frame_begin();
    xfer(8'h00, 8, mi, ex, lat);
    checks++;
    if ({mi, TX_FULL} !== {8'h11, 1'b0}) begin
      errors++; $display("FAIL double_wr_miso: miso/full got %h/%b expected 11/0", mi, TX_FULL);
    end
    frame_end();
    rx_ack();
  endtask

  task automatic test_wr_at_load();
    logic [7:0] mi, ex, want; int lat;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) tx_write(8'h5A);
      want = (k == 0) ? 8'h5A : 8'hFF;
      SS = 1'b0;
      model_take();
      tick(2);
      TX_DATA = 8'hC3; TX_WR = 1'b1;
      tick(1);
      TX_WR = 1'b0;
      m_tx_buf = 8'hC3; m_tx_full = 1'b1;
      tick(SETUP - 3);
      checks++;
      if (TX_FULL !== 1'b1) begin errors++; $display("FAIL wr_load_full[%0d]: got %b expected 1", k, TX_FULL); end
      xfer(8'h0F, 8, mi, ex, lat);
      checks++;
      if (mi !== want) begin errors++; $display("FAIL wr_load_old[%0d]: got %h expected %h", k, mi, want); end
      rx_ack();
      xfer(8'hF0, 8, mi, ex, lat);
      checks++;
      if (mi !== 8'hC3) begin errors++; $display("FAIL wr_load_new[%0d]: got %h expected c3", k, mi); end
      frame_end();
      rx_ack();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, ex; int lat;
    tx_write(8'h77);
    frame_begin();
    xfer(8'hA0, 3, mi, ex, lat);
    RES_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({MISO, MISO_OE, FRAME, TX_FULL, RX_VALID, OVERRUN, RX_DATA} !== 14'h0) begin
      errors++;
      $display("FAIL reset_mid: got %b_%b_%b_%b_%b_%b_%h expected all zero",
               MISO, MISO_OE, FRAME, TX_FULL, RX_VALID, OVERRUN, RX_DATA);
    end
    tick(2);
    SS = 1'b1;
    tick(2);
    RES_N = 1'b1;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      SCLK = 1'b0; tick(H);
      SCLK = 1'b1; tick(H);
    end
    checks++;
    if ({MISO_OE, FRAME, RX_VALID, TX_FULL, OVERRUN} !== 5'b00000) begin
      errors++; $display("FAIL reset_idle_sclk: oe/frame/valid/full/ovr got %b expected 00000",
                         {MISO_OE, FRAME, RX_VALID, TX_FULL, OVERRUN});
    end
    frame_begin();
    xfer(8'hC5, 8, mi, ex, lat);
    checks++;
    if ({mi, RX_DATA, RX_VALID} !== {8'hFF, 8'hC5, 1'b1}) begin
      errors++; $display("FAIL reset_next_frame: miso/rx/valid got %h/%h/%b expected ff/c5/1", mi, RX_DATA, RX_VALID);
    end
    frame_end();
    rx_ack();
  endtask

  task automatic test_random();
    logic [7:0] mi, ex, mo; int lat, nb, part;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      nb = $urandom_range(1, 3);
      frame_begin();
      for (int b = 0; b < nb; b++) begin
        mo = 8'($urandom);
        xfer(mo, 8, mi, ex, lat);
        checks++;
        if (mi !== ex) begin errors++; $display("FAIL rand_miso f%0d b%0d: got %h expected %h", f, b, mi, ex); end
        checks++;
        if ({RX_VALID, RX_DATA, OVERRUN, TX_FULL} !== {m_rx_valid, m_rx_data, m_ovr, m_tx_full}) begin
          errors++;
          $display("FAIL rand_state f%0d b%0d: valid/rx/ovr/full got %b/%h/%b/%b expected %b/%h/%b/%b",
                   f, b, RX_VALID, RX_DATA, OVERRUN, TX_FULL, m_rx_valid, m_rx_data, m_ovr, m_tx_full);
        end
        if ($urandom_range(0, 2) != 0) rx_ack();
        if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
        if ($urandom_range(0, 3) == 0) ovr_clear();
      end
      if ($urandom_range(0, 5) == 0) begin
        part = $urandom_range(1, 7);
        xfer(8'($urandom), part, mi, ex, lat);
        checks++;
        if (mi !== ex) begin errors++; $display("FAIL rand_partial f%0d: got %h expected %h", f, mi, ex); end
      end
      frame_end();
      checks++;
      if ({MISO_OE, RX_VALID, RX_DATA, OVERRUN, TX_FULL} !== {1'b0, m_rx_valid, m_rx_data, m_ovr, m_tx_full}) begin
        errors++;
        $display("FAIL rand_end f%0d: oe/valid/rx/ovr/full got %b/%b/%h/%b/%b expected 0/%b/%h/%b/%b",
                 f, MISO_OE, RX_VALID, RX_DATA, OVERRUN, TX_FULL, m_rx_valid, m_rx_data, m_ovr, m_tx_full);
      end
    end
  endtask

  initial begin
    RES_N = 1'b0; SS = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    TX_DATA = 8'h00; TX_WR = 1'b0; RX_ACK = 1'b0; OVR_CLR = 1'b0;
    model_reset();
    tick(3);
    test_reset();
    test_preload();
    test_fill_ack();
    test_overrun();
    test_abort();
    test_double_wr();
    test_wr_at_load();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
